// File: rtl/cpu_pkg.sv
// Shared types for the 19-bit CPU execute/writeback path.
// Used by logic_writeback_stage and wb_fifo2 (optional LOGIC_WB_FWD_EN forwarding port).
package cpu_pkg;

  localparam int WORD_SIZE  = 19;
  localparam int REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2,
    OP_NOT = 2'd3
  } logic_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic p;
  } status_flags_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WORD_SIZE-1:0]  data;
  } wb_entry_t;

  function automatic status_flags_t calc_flags(input logic [WORD_SIZE-1:0] word);
    status_flags_t f;
    f.z = (word == '0);
    f.n = word[WORD_SIZE-1];
    f.p = ^word;
    return f;
  endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order register FIFO of wb_entry_t with 1-bit head/tail pointers and a separate count.
// With LOGIC_WB_FWD_EN defined it also exposes the youngest entry (tail-1 slot).
module wb_fifo2
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output wb_entry_t dout,
`ifdef LOGIC_WB_FWD_EN
  output wb_entry_t youngest,
`endif
  output logic [1:0] count
);

  wb_entry_t  mem [2];
  wb_entry_t  last_q;
  logic       head_ptr;
  logic       tail_ptr;
  logic       do_push;
  logic       do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);

  // When empty, dout keeps showing the entry most recently presented at the head.
  assign dout = (count != 2'd0) ? mem[head_ptr] : last_q;

`ifdef LOGIC_WB_FWD_EN
  assign youngest = mem[~tail_ptr];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      last_q   <= '0;
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (count != 2'd0) last_q <= mem[head_ptr];
      if (flush) begin
        head_ptr <= 1'b0;
        tail_ptr <= 1'b0;
        count    <= 2'd0;
      end else begin
        if (do_push) begin
          mem[tail_ptr] <= din;
          tail_ptr      <= ~tail_ptr;
        end
        if (do_pop) head_ptr <= ~head_ptr;
        case ({do_push, do_pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/logic_writeback_stage.sv
// Logical-unit writeback stage: flags update, r0 filter and a 2-deep queue to the register file.
// Optional macro LOGIC_WB_FWD_EN adds fwd_valid/fwd_rd/fwd_data (youngest queued entry).
module logic_writeback_stage
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_SIZE-1:0]  in_result,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [WORD_SIZE-1:0]  wb_data,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic                  flag_p
`ifdef LOGIC_WB_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [WORD_SIZE-1:0]  fwd_data
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
  // depends on ready, and in_ready depends only on registered queue occupancy.

  logic [1:0]    count;
  logic          accept;
  logic          push;
  logic          pop;
  wb_entry_t     in_entry;
  wb_entry_t     head;
  status_flags_t flags_q;

  assign in_ready = (count != 2'd2);
  assign accept   = in_valid && in_ready && !flush;
  // r0 is hardwired to zero, so its results only affect the flags.
  assign push     = accept && (in_rd != '0);
  assign wb_valid = (count != 2'd0);
  assign pop      = wb_valid && wb_ready;

  assign in_entry.rd   = in_rd;
  assign in_entry.data = in_result;

  wb_fifo2 u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (push),
    .din      (in_entry),
    .pop      (pop),
    .dout     (head),
`ifdef LOGIC_WB_FWD_EN
    .youngest ({fwd_rd, fwd_data}),
`endif
    .count    (count)
  );

`ifdef LOGIC_WB_FWD_EN
  assign fwd_valid = (count != 2'd0);
`endif

  assign wb_rd   = head.rd;
  assign wb_data = head.data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (accept) begin
      flags_q <= calc_flags(in_result);
    end
  end

  assign flag_z = flags_q.z;
  assign flag_n = flags_q.n;
  assign flag_p = flags_q.p;

endmodule

// File: tb/tb_logic_writeback_stage.sv
// Directed bench for logic_writeback_stage: expected writes queued in exp_q, checked at negedge.
module tb_logic_writeback_stage;

  localparam int W  = 19;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_result;
  logic [RW-1:0] in_rd;
  logic          wb_valid;
  logic          wb_ready;
  logic [RW-1:0] wb_rd;
  logic [W-1:0]  wb_data;
  logic          flag_z;
  logic          flag_n;
  logic          flag_p;
`ifdef LOGIC_WB_FWD_EN
  logic          fwd_valid;
  logic [RW-1:0] fwd_rd;
  logic [W-1:0]  fwd_data;
`endif

  logic [RW+W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  logic_writeback_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_rd     (in_rd),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_p    (flag_p)
`ifdef LOGIC_WB_FWD_EN
    ,
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every completed write must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && !flush && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected_write", {9'd0, wb_rd, wb_data}, 32'hFFFF_FFFF);
      end else begin
        check("wb_write", {9'd0, wb_rd, wb_data}, {9'd0, exp_q.pop_front()});
      end
    end
  end

  // Driver: offer one result, wait (bounded) for in_ready, complete the handshake.
  task automatic send(input logic [RW-1:0] rd, input logic [W-1:0] data);
    int n;
    in_valid  = 1'b1;
    in_rd     = rd;
    in_result = data;
    if (rd != '0) exp_q.push_back({rd, data});
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("accept_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_rd     = '0;
    in_result = '0;
    wb_ready  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_flags", {flag_z, flag_n, flag_p}, 3'b000);

    // single result, one-cycle latency
    wb_ready = 1'b1;
    send(4'd3, 19'h7FFFF);
    check("single_wb_valid", wb_valid, 1);
    check("single_wb_rd", wb_rd, 3);
    check("single_wb_data", wb_data, 19'h7FFFF);
    check("single_flags", {flag_z, flag_n, flag_p}, 3'b011);
    tick();
    check("single_empty", wb_valid, 0);
    check("single_sb_empty", exp_q.size(), 0);

    // backpressure
    wb_ready = 1'b0;
    send(4'd1, 19'h00001);
    check("bp_flags_1", {flag_z, flag_n, flag_p}, 3'b001);
    send(4'd2, 19'h00002);
    check("bp_in_ready_full", in_ready, 0);
`ifdef LOGIC_WB_FWD_EN
    check("bp_fwd_valid", fwd_valid, 1);
    check("bp_fwd_rd", fwd_rd, 2);
    check("bp_fwd_data", fwd_data, 19'h00002);
`endif
    in_valid  = 1'b1;
    in_rd     = 4'd3;
    in_result = 19'h00003;
    exp_q.push_back({4'd3, 19'h00003});
    tick();
    tick();
    check("bp_held_in_ready", in_ready, 0);
    check("bp_head_rd", wb_rd, 1);
    check("bp_head_data", wb_data, 19'h00001);
    check("bp_flags_held", {flag_z, flag_n, flag_p}, 3'b001);
    wb_ready = 1'b1;
    tick();
    check("bp_in_ready_after_pop", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_flags_3", {flag_z, flag_n, flag_p}, 3'b000);
    wait_drain("bp_drain");
    tick();
    check("bp_idle", wb_valid, 0);

    // r0 discard: handshake completes, nothing queued, flags still update
    send(4'd0, 19'h00000);
    check("r0_wb_valid", wb_valid, 0);
    check("r0_flags", {flag_z, flag_n, flag_p}, 3'b100);
    check("r0_retain_rd", wb_rd, 3);
    check("r0_retain_data", wb_data, 19'h00003);
    tick();
    check("r0_wb_valid_later", wb_valid, 0);

    // sustained throughput with simultaneous push/pop
    wb_ready = 1'b1;
    exp_q.push_back({4'd4, 19'h1});
    exp_q.push_back({4'd5, 19'h2});
    exp_q.push_back({4'd6, 19'h3});
    in_valid = 1'b1; in_rd = 4'd4; in_result = 19'h1;
    tick();
    check("tp_rd_4", wb_rd, 4);
    check("tp_ready_4", in_ready, 1);
    in_rd = 4'd5; in_result = 19'h2;
    tick();
    check("tp_rd_5", wb_rd, 5);
    check("tp_valid_5", wb_valid, 1);
    check("tp_ready_5", in_ready, 1);
    in_rd = 4'd6; in_result = 19'h3;
    tick();
    in_valid = 1'b0;
    check("tp_rd_6", wb_rd, 6);
    check("tp_ready_6", in_ready, 1);
    tick();
    check("tp_empty", wb_valid, 0);
    check("tp_sb_empty", exp_q.size(), 0);

    // flush with two queued entries; coincident input and pop are dropped
    wb_ready = 1'b0;
    send(4'd1, 19'h40000);
    send(4'd2, 19'h00007);
    check("fl_flags_before", {flag_z, flag_n, flag_p}, 3'b001);
    check("fl_full", in_ready, 0);
    flush     = 1'b1;
    wb_ready  = 1'b1;
    in_valid  = 1'b1;
    in_rd     = 4'd7;
    in_result = 19'h12345;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    check("fl_wb_valid", wb_valid, 0);
    check("fl_in_ready", in_ready, 1);
    check("fl_flags_kept", {flag_z, flag_n, flag_p}, 3'b001);
    check("fl_retain_data", wb_data, 19'h40000);
    repeat (3) tick();
    check("fl_no_r7", wb_valid, 0);

    // reset mid-drain
    wb_ready = 1'b0;
    send(4'd5, 19'h55555);
    check("rm_wb_valid", wb_valid, 1);
    check("rm_flags", {flag_z, flag_n, flag_p}, 3'b010);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    check("rm_wb_valid_after", wb_valid, 0);
    check("rm_flags_after", {flag_z, flag_n, flag_p}, 3'b000);
    check("rm_in_ready", in_ready, 1);
    check("rm_wb_data", wb_data, 0);
`ifdef LOGIC_WB_FWD_EN
    check("rm_fwd_valid", fwd_valid, 0);
`endif
    wb_ready = 1'b1;
    repeat (2) tick();
    check("rm_idle", wb_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
